load_ext_unit: RTL and testbench

Parametrised, pipelined load-data extract-and-extend stage for the MIPS SoC datapath. It selects a byte, halfword, word or doubleword lane from a `DATA_W`-wide memory read word and zero- or sign-extends it to full width. It also flags misaligned accesses and keeps a saturating error count. It sits between the data-memory read port and the writeback mux, with one register stage and a valid/ready handshake on both sides.

---
 rtl/load_ext_unit.sv | 111 +++++++++++
 tb/tb_load_ext_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/load_ext_unit.sv
// Load-data lane extract and zero/sign extend stage with a one-beat output
// register, valid/ready handshake and a saturating misalignment error count.
module load_ext_unit #(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [1:0]        in_size,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [7:0]        err_cnt,
    input  logic              err_clr
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_err_q, out_err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] keep;
    logic [DATA_W-1:0] ext;
    logic [OFF_W-1:0]  off_mask;
    logic              msb;
    logic              err;
    logic              accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign lane     = in_data >> {in_off, 3'b000};

    always_comb begin
        keep     = '1;
        msb      = lane[DATA_W-1];
        off_mask = '1;
        unique case (in_size)
            2'b00: begin
                keep     = DATA_W'(8'hFF);
                msb      = lane[7];
                off_mask = '0;
            end
            2'b01: begin
                keep     = DATA_W'(16'hFFFF);
                msb      = lane[15];
                off_mask = OFF_W'(1);
            end
            2'b10: begin
                keep     = DATA_W'(32'hFFFF_FFFF);
                msb      = lane[31];
                off_mask = OFF_W'(3);
            end
            2'b11: begin
                keep     = '1;
                msb      = lane[DATA_W-1];
                off_mask = '1;
            end
        endcase
    end

    // A full-width lane has keep all ones, so the fill term vanishes.
    assign ext = (lane & keep) | ((in_sign && msb) ? ~keep : '0);
    assign err = ((in_off & off_mask) != '0) ||
                 ((in_size == 2'b11) && (DATA_W == 32));

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        err_cnt_d   = err_cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = err ? '0 : ext;
            out_err_d   = err;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (accept && err && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_load_ext_unit.sv
// Directed bench for load_ext_unit at 32- and 64-bit widths.
module tb_load_ext_unit;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, in_sign, out_valid, out_ready;
    logic        out_err, err_clr;
    logic [31:0] in_data, out_data;
    logic [1:0]  in_off, in_size;
    logic [7:0]  err_cnt;

    logic        w_in_valid, w_in_ready, w_in_sign, w_out_valid;
    logic        w_out_ready, w_out_err, w_err_clr;
    logic [63:0] w_in_data, w_out_data;
    logic [2:0]  w_in_off;
    logic [1:0]  w_in_size;
    logic [7:0]  w_err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_ext_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_off(in_off),
        .in_size(in_size), .in_sign(in_sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err),
        .err_cnt(err_cnt), .err_clr(err_clr)
    );

    load_ext_unit #(.DATA_W(64)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .in_off(w_in_off),
        .in_size(w_in_size), .in_sign(w_in_sign),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_data(w_out_data), .out_err(w_out_err),
        .err_cnt(w_err_cnt), .err_clr(w_err_clr)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] off,
                        input logic [1:0] sz, input logic sg);
        in_data  = d;
        in_off   = off;
        in_size  = sz;
        in_sign  = sg;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic beat64(input logic [63:0] d, input logic [2:0] off,
                          input logic [1:0] sz, input logic sg);
        w_in_data  = d;
        w_in_off   = off;
        w_in_size  = sz;
        w_in_sign  = sg;
        w_in_valid = 1'b1;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
    endtask

    logic [31:0] vec [4];
    logic [31:0] held;
    localparam logic [31:0] D  = 32'h8070_F0A5;
    localparam logic [63:0] DW = 64'h8000_0000_1234_5678;

    initial begin
        int sent;
        int got;
        int cyc;
        rst_n = 1'b0;
        in_valid = 0; in_data = '0; in_off = '0; in_size = '0;
        in_sign = 0; out_ready = 1; err_clr = 0;
        w_in_valid = 0; w_in_data = '0; w_in_off = '0; w_in_size = '0;
        w_in_sign = 0; w_out_ready = 1; w_err_clr = 0;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_err", out_err, 0);
        check("rst_cnt", err_cnt, 0);
        check("rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        beat(D, 2'd0, 2'b00, 1'b1);
        check("b_s_valid", out_valid, 1);
        check("b_s", out_data, 32'hFFFF_FFA5);
        check("b_s_err", out_err, 0);
        beat(D, 2'd0, 2'b00, 1'b0);
        check("b_z", out_data, 32'h0000_00A5);
        beat(D, 2'd2, 2'b01, 1'b1);
        check("h_s", out_data, 32'hFFFF_8070);
        beat(D, 2'd2, 2'b01, 1'b0);
        check("h_z", out_data, 32'h0000_8070);
        beat(D, 2'd3, 2'b00, 1'b1);
        check("b3_s", out_data, 32'hFFFF_FF80);
        beat(D, 2'd0, 2'b10, 1'b1);
        check("w_full", out_data, D);
        check("w_full_err", out_err, 0);

        beat(D, 2'd1, 2'b01, 1'b1);
        check("mis_h_err", out_err, 1);
        check("mis_h_data", out_data, 0);
        check("mis_h_cnt", err_cnt, 1);
        beat(D, 2'd2, 2'b10, 1'b0);
        check("mis_w_cnt", err_cnt, 2);
        beat(D, 2'd0, 2'b11, 1'b0);
        check("dw32_err", out_err, 1);
        check("dw32_cnt", err_cnt, 3);

        err_clr = 1'b1;
        beat(D, 2'd1, 2'b01, 1'b0);
        err_clr = 1'b0;
        check("clr_pri_cnt", err_cnt, 0);
        check("clr_pri_err", out_err, 1);

        in_data = D; in_off = 2'd1; in_size = 2'b01; in_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("sat_cnt", err_cnt, 255);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("clr_cnt", err_cnt, 0);
        check("drained", out_valid, 0);

        vec[0] = 32'h1111_0001; vec[1] = 32'h2222_0002;
        vec[2] = 32'h3333_0003; vec[3] = 32'h4444_0004;
        sent = 0; got = 0; cyc = 0; held = '0;
        in_off = 2'd0; in_size = 2'b10; in_sign = 1'b0;
        while (got < 4 && cyc < 20) begin
            out_ready = !(cyc == 2 || cyc == 3);
            in_valid  = (sent < 4);
            in_data   = vec[sent < 4 ? sent : 3];
            @(negedge clk);
            if (!out_ready) begin
                check("stall_ready", in_ready, 0);
                check("stall_valid", out_valid, 1);
                if (cyc == 3) check("stall_hold", out_data, held);
                held = out_data;
            end
            if (out_valid && out_ready) begin
                check("bp_data", out_data, vec[got]);
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", got, 4);
        check("bp_cycles", cyc, 7);
        @(posedge clk);
        #1;

        repeat (5) beat(D, 2'd1, 2'b01, 1'b0);
        out_ready = 1'b0;
        beat(D, 2'd0, 2'b00, 1'b1);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_cnt", err_cnt, 5);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        beat(D, 2'd2, 2'b01, 1'b1);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_data", out_data, 32'hFFFF_8070);

        beat64(DW, 3'd4, 2'b10, 1'b1);
        check("d64_w4_s", w_out_data, 64'hFFFF_FFFF_8000_0000);
        beat64(DW, 3'd0, 2'b10, 1'b0);
        check("d64_w0_z", w_out_data, 64'h0000_0000_1234_5678);
        beat64(DW, 3'd0, 2'b11, 1'b1);
        check("d64_dw", w_out_data, DW);
        check("d64_dw_err", w_out_err, 0);
        beat64(DW, 3'd4, 2'b11, 1'b0);
        check("d64_dw4_err", w_out_err, 1);
        check("d64_dw4_data", w_out_data, 0);
        check("d64_cnt", w_err_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
